// File: rtl/fifo_flow_ctrl_if.sv
// fifo_flow_ctrl_if: request/threshold inputs and strobe/status outputs of the FIFO flow controller
interface fifo_flow_ctrl_if #(parameter int PTR_L = 3);
  logic             init;
  logic [PTR_L-1:0] umbral_hi;
  logic [PTR_L-1:0] umbral_lo;
  logic             fifo_wr;
  logic             fifo_rd;
  logic             push;
  logic             pop;
  logic [PTR_L-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             almost_full;
  logic             almost_empty;
  logic [2:0]       state;
  logic             error;
  logic             idle;
  modport master (
    output init, umbral_hi, umbral_lo, fifo_wr, fifo_rd,
    input  push, pop, count, fifo_full, fifo_empty, almost_full, almost_empty, state, error, idle
  );
  modport slave (
    input  init, umbral_hi, umbral_lo, fifo_wr, fifo_rd,
    output push, pop, count, fifo_full, fifo_empty, almost_full, almost_empty, state, error, idle
  );
endinterface

// File: rtl/fifo_flow_ctrl.sv
// fifo_flow_ctrl: qualifies FIFO write/read requests, tracks occupancy, flags and a sticky error
module fifo_flow_ctrl #(
  parameter int MEM_SIZE  = 4,
  parameter int WORD_SIZE = 6,
  parameter int PTR_L     = 3
) (
  input logic             clk,
  input logic             reset,
  fifo_flow_ctrl_if.slave fc
);
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;
  localparam logic [PTR_L-1:0] FULL = PTR_L'(MEM_SIZE);
  // an unrepresentable depth or empty data word is treated as a bad configuration at INIT exit
  localparam bit CFG_OK = ((2 ** PTR_L) > MEM_SIZE) && (WORD_SIZE > 0);
  state_t           state_q, state_d;
  logic [PTR_L-1:0] count_q, count_d;
  logic [PTR_L-1:0] hi_q, hi_d;
  logic [PTR_L-1:0] lo_q, lo_d;
  logic             push_q, push_d;
  logic             pop_q, pop_d;
  logic             error_q, error_d;
  logic             bad_cfg;
  logic             full;
  assign full    = count_q == FULL;
  assign bad_cfg = !CFG_OK || fc.umbral_lo >= fc.umbral_hi || fc.umbral_hi > FULL;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      count_q <= '0;
      hi_q    <= PTR_L'(MEM_SIZE - 1);
      lo_q    <= PTR_L'(1);
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      error_q <= error_d;
    end
  end
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    push_d  = 1'b0;
    pop_d   = 1'b0;
    error_d = error_q;
    case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT: begin
        hi_d = fc.umbral_hi;
        lo_d = fc.umbral_lo;
        if (!fc.init) begin
          state_d = bad_cfg ? S_ERROR : S_IDLE;
          error_d = bad_cfg;
        end
      end
      S_IDLE: begin
        if (fc.init) state_d = S_INIT;
        else if (fc.fifo_rd) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else if (fc.fifo_wr) begin
          state_d = S_ACTIVE;
          push_d  = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      S_ACTIVE: begin
        if (fc.fifo_wr && fc.fifo_rd) begin
          push_d = 1'b1;
          pop_d  = 1'b1;
        end else if (fc.fifo_wr) begin
          state_d = full ? S_ERROR : S_ACTIVE;
          error_d = full;
          push_d  = !full;
          count_d = full ? count_q : count_q + 1'b1;
        end else if (fc.fifo_rd) begin
          pop_d   = 1'b1;
          count_d = count_q - 1'b1;
          state_d = count_q == PTR_L'(1) ? S_IDLE : S_ACTIVE;
        end
      end
      S_ERROR: error_d = 1'b1;
      default: state_d = S_RESET;
    endcase
  end
  assign fc.push         = push_q;
  assign fc.pop          = pop_q;
  assign fc.count        = count_q;
  assign fc.fifo_full    = full;
  assign fc.fifo_empty   = count_q == '0;
  assign fc.almost_full  = count_q >= hi_q;
  assign fc.almost_empty = count_q <= lo_q;
  assign fc.state        = state_q;
  assign fc.error        = error_q;
  assign fc.idle         = state_q == S_IDLE;
endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// tb_fifo_flow_ctrl: directed and random checking of fifo_flow_ctrl against an occupancy-queue model
module tb_fifo_flow_ctrl;
  localparam int MEM = 4;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_state;
  int   m_q[$];
  int   m_hi, m_lo;
  logic m_push, m_pop, m_err;
  fifo_flow_ctrl_if #(.PTR_L(3)) fc ();
  fifo_flow_ctrl #(.MEM_SIZE(MEM), .WORD_SIZE(6), .PTR_L(3)) dut (
    .clk  (clk),
    .reset(reset),
    .fc   (fc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic model(input logic r, input logic in, input int uh, input int ul, input logic w, input logic rd);
    m_push = 1'b0;
    m_pop  = 1'b0;
    if (r) begin
      m_state = 0;
      m_q.delete();
      m_err = 1'b0;
      m_hi  = MEM - 1;
      m_lo  = 1;
    end else if (m_state == 0) m_state = 1;
    else if (m_state == 1) begin
      m_hi = uh;
      m_lo = ul;
      if (!in) begin
        m_err   = (ul >= uh) || (uh > MEM);
        m_state = m_err ? 4 : 2;
      end
    end else if (m_state == 2) begin
      if (in) m_state = 1;
      else if (rd) begin
        m_state = 4;
        m_err   = 1'b1;
      end else if (w) begin
        m_q.push_back(0);
        m_push  = 1'b1;
        m_state = 3;
      end
    end else if (m_state == 3) begin
      if (w && rd) begin
        m_q.push_back(0);
        void'(m_q.pop_front());
        m_push = 1'b1;
        m_pop  = 1'b1;
      end else if (w && m_q.size() == MEM) begin
        m_state = 4;
        m_err   = 1'b1;
      end else if (w) begin
        m_q.push_back(0);
        m_push = 1'b1;
      end else if (rd) begin
        void'(m_q.pop_front());
        m_pop = 1'b1;
        if (m_q.size() == 0) m_state = 2;
      end
    end
  endtask
  task automatic step(input logic r, input logic in, input int uh, input int ul, input logic w, input logic rd);
    int c;
    reset        = r;
    fc.init      = in;
    fc.umbral_hi = 3'(uh);
    fc.umbral_lo = 3'(ul);
    fc.fifo_wr   = w;
    fc.fifo_rd   = rd;
    @(posedge clk);
    model(r, in, uh, ul, w, rd);
    #1;
    c = m_q.size();
    chk("state", 8'(fc.state), 8'(m_state));
    chk("count", 8'(fc.count), 8'(c));
    chk("push", 8'(fc.push), 8'(m_push));
    chk("pop", 8'(fc.pop), 8'(m_pop));
    chk("error", 8'(fc.error), 8'(m_err));
    chk("flags{full,empty,af,ae,idle}",
        8'({fc.fifo_full, fc.fifo_empty, fc.almost_full, fc.almost_empty, fc.idle}),
        8'({c == MEM, c == 0, c >= m_hi, c <= m_lo, m_state == 2}));
  endtask
  task automatic do_init(input int uh, input int ul);
    step(1, 0, uh, ul, 0, 0);
    step(0, 1, uh, ul, 0, 0);
    step(0, 0, uh, ul, 0, 0);
  endtask
  initial begin
    int uh, ul;
    logic r, in, w, rd;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 3, 1, 0, 0);
    step(0, 1, 3, 1, 0, 0);
    step(0, 0, 3, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 3, 1, 1, 0);
    step(0, 0, 3, 1, 1, 1);
    step(0, 0, 3, 1, 1, 0);
    step(0, 0, 3, 1, 0, 1);
    do_init(3, 1);
    step(0, 0, 3, 1, 0, 1);
    step(1, 0, 3, 1, 0, 0);
    do_init(2, 2);
    do_init(5, 1);
    do_init(3, 1);
    step(0, 0, 3, 1, 1, 0);
    step(0, 0, 3, 1, 1, 0);
    step(0, 0, 3, 1, 0, 1);
    step(0, 0, 3, 1, 0, 1);
    step(0, 1, 3, 1, 1, 1);
    step(0, 0, 4, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 99) < 2) || (m_state == 4 && $urandom_range(0, 3) == 0);
      in = (m_state <= 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) != 0) begin
        uh = $urandom_range(1, MEM);
        ul = $urandom_range(0, uh - 1);
      end else begin
        uh = $urandom_range(0, 7);
        ul = $urandom_range(0, 7);
      end
      w  = $urandom_range(0, 1) == 1;
      rd = $urandom_range(0, 2) == 0;
      step(r, in, uh, ul, w, rd);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
